// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and pointer-width rule for the dual-clock FIFO.
package fifo_pkg;

  localparam int FIFO_DATASIZE = 8;
  localparam int FIFO_ADDRSIZE = 4;

  // One extra pointer bit beyond the address tells full and empty apart.
  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

  localparam int FIFO_PTRW = ptr_width(FIFO_ADDRSIZE);

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: registered valid/ready output stream of the FIFO read side.
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE
);

  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);

endinterface

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: combinational Gray-to-binary conversion (prefix XOR from MSB).
module fifo_gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at and above its position.
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the dual-clock FIFO (rclk domain).
// Owns the read pointer, the empty flag and a registered output stage.
// Optional occupancy estimate rlevel is built when FIFO_RD_LEVEL_EN is defined;
// otherwise rlevel is tied to zero.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter  int DATASIZE = FIFO_DATASIZE,
  parameter  int ADDRSIZE = FIFO_ADDRSIZE,
  localparam int PTRW     = ptr_width(ADDRSIZE)
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [PTRW-1:0]     rq2_wptr,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [PTRW-1:0]     rptr,
  output logic                rempty,
  output logic [PTRW-1:0]     rlevel,
  fifo_rd_ctrl_if.master      rd_if
);

  logic [PTRW-1:0] rbin;
  logic [PTRW-1:0] rbinnext;
  logic [PTRW-1:0] rgraynext;
  logic            rinc;

  // Fetch whenever a word is available and the output register is free or draining.
  always_comb begin
    rinc      = !rempty && (!rd_if.dout_valid || rd_if.dout_ready);
    rbinnext  = rbin + {{(PTRW-1){1'b0}}, rinc};
    rgraynext = (rbinnext >> 1) ^ rbinnext;
  end

  assign raddr = rbin[ADDRSIZE-1:0];

  // Read pointer (binary and Gray) and registered empty flag.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
    end
  end

  // Output register: load on fetch, clear valid when consumed without refill.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_if.dout       <= '0;
      rd_if.dout_valid <= 1'b0;
    end else if (rinc) begin
      rd_if.dout       <= rdata_mem;
      rd_if.dout_valid <= 1'b1;
    end else if (rd_if.dout_valid && rd_if.dout_ready) begin
      rd_if.dout_valid <= 1'b0;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PTRW-1:0] wbin;

  fifo_gray2bin #(.WIDTH(PTRW)) u_wptr_g2b (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  // Occupancy against the post-edge read pointer; the synchronized write
  // pointer lags the real one, so the estimate never overstates.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel <= '0;
    end else begin
      rlevel <= wbin - rbinnext;
    end
  end
`else
  assign rlevel = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed stimulus with a scoreboard-checked output stream.
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [4:0] rq2_wptr;
  logic [7:0] rdata_mem;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic [4:0] rlevel;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];

  int checks   = 0;
  int failures = 0;
  int rb       = 0;

  fifo_rd_ctrl_if #(.DATASIZE(8)) rd_if ();

  fifo_rd_ctrl #(.DATASIZE(8), .ADDRSIZE(4)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rdata_mem (rdata_mem),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rlevel    (rlevel),
    .rd_if     (rd_if)
  );

  assign rdata_mem = mem[raddr];

  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  function automatic int lvl(input int v);
`ifdef FIFO_RD_LEVEL_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge rclk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Writer pushes one word per cycle; reader should keep pace with no empties.
  task automatic stream(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      @(posedge rclk);
      #1;
      mem[rb % 16] = base + k[7:0];
      exp_q.push_back(base + k[7:0]);
      rb = (rb + 1) % 32;
      rq2_wptr = gray(rb);
      @(negedge rclk);
      if (k >= 1) chk("stream_rempty", {31'd0, rempty}, 32'd0);
    end
  endtask

  // Monitor: every accepted output word is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge rclk);
      if (rrst_n === 1'b1 && rd_if.dout_valid === 1'b1 && rd_if.dout_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL dout_unexpected: got %0h expected none", rd_if.dout);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rd_if.dout !== e) begin
            failures++;
            $display("FAIL dout_word: got %0h expected %0h", rd_if.dout, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst_n = 1'b0;
    rq2_wptr = 5'b10101;
    rd_if.dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'hF0 - i[7:0];

    // Reset state with arbitrary inputs
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    chk("rst_rempty", {31'd0, rempty}, 32'd1);
    chk("rst_valid", {31'd0, rd_if.dout_valid}, 32'd0);
    chk("rst_rptr", {27'd0, rptr}, 32'd0);
    chk("rst_raddr", {28'd0, raddr}, 32'd0);
    chk("rst_dout", {24'd0, rd_if.dout}, 32'd0);
    chk("rst_rlevel", {27'd0, rlevel}, 32'd0);
    rq2_wptr = 5'd0;
    @(posedge rclk);
    #2 rrst_n = 1'b1;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("idle_rempty", {31'd0, rempty}, 32'd1);

    // Streaming three words
    @(posedge rclk);
    #1;
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2;
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    rq2_wptr = 5'b00010;
    rb = 3;
    drain(20);
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("stream_end_rempty", {31'd0, rempty}, 32'd1);
    chk("stream_end_valid", {31'd0, rd_if.dout_valid}, 32'd0);
    chk("stream_end_rptr", {27'd0, rptr}, 32'h02);
    chk("stream_end_raddr", {28'd0, raddr}, 32'd3);
    chk("stream_end_rlevel", {27'd0, rlevel}, 32'd0);

    // Backpressure with level: rbin stalls at 4, write pointer at 10
    @(posedge rclk);
    #1;
    rd_if.dout_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem[3 + i] = 8'h30 + i[7:0];
      exp_q.push_back(8'h30 + i[7:0]);
    end
    rq2_wptr = gray(10);
    rb = 10;
    repeat (4) @(posedge rclk);
    @(negedge rclk);
    chk("bp_valid", {31'd0, rd_if.dout_valid}, 32'd1);
    chk("bp_dout", {24'd0, rd_if.dout}, 32'h30);
    chk("bp_rptr", {27'd0, rptr}, {27'd0, gray(4)});
    chk("bp_raddr", {28'd0, raddr}, 32'd4);
    chk("bp_rempty", {31'd0, rempty}, 32'd0);
    chk("level_6", {27'd0, rlevel}, lvl(6));
    @(posedge rclk);
    #1 rd_if.dout_ready = 1'b1;
    @(posedge rclk);
    #1 rd_if.dout_ready = 1'b0;
    @(negedge rclk);
    chk("bp_step_dout", {24'd0, rd_if.dout}, 32'h31);
    chk("bp_step_valid", {31'd0, rd_if.dout_valid}, 32'd1);
    chk("bp_step_rptr", {27'd0, rptr}, {27'd0, gray(5)});
    chk("level_5", {27'd0, rlevel}, lvl(5));
    @(posedge rclk);
    #1 rd_if.dout_ready = 1'b1;
    drain(40);
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("bp_end_rempty", {31'd0, rempty}, 32'd1);
    chk("bp_end_rptr", {27'd0, rptr}, {27'd0, gray(10)});

    // Wrap: 40 words push raddr through 15->0 and rbin through 31->0
    stream(40, 8'h40);
    drain(20);
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("wrap_rptr", {27'd0, rptr}, {27'd0, gray(18)});
    chk("wrap_raddr", {28'd0, raddr}, 32'd2);
    stream(11, 8'h80);
    drain(20);
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("pre_level_rptr", {27'd0, rptr}, {27'd0, gray(29)});

    // Level across the pointer wrap: rbin stalls at 30, write pointer at 2
    @(posedge rclk);
    #1;
    rd_if.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) mem[(29 + i) % 16] = 8'hD0 + i[7:0];
    rq2_wptr = gray(2);
    repeat (4) @(posedge rclk);
    @(negedge rclk);
    chk("wrap_stall_dout", {24'd0, rd_if.dout}, 32'hD0);
    chk("wrap_stall_rptr", {27'd0, rptr}, 32'h11);
    chk("wrap_stall_raddr", {28'd0, raddr}, 32'd14);
    chk("level_4", {27'd0, rlevel}, lvl(4));

    // Asynchronous reset while stalled discards the held word
    #2 rrst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_valid", {31'd0, rd_if.dout_valid}, 32'd0);
    chk("async_rst_rptr", {27'd0, rptr}, 32'd0);
    chk("async_rst_raddr", {28'd0, raddr}, 32'd0);
    chk("async_rst_rempty", {31'd0, rempty}, 32'd1);
    chk("async_rst_dout", {24'd0, rd_if.dout}, 32'd0);
    chk("async_rst_rlevel", {27'd0, rlevel}, 32'd0);
    rq2_wptr = 5'd0;
    repeat (2) @(posedge rclk);
    #2 rrst_n = 1'b1;
    rd_if.dout_ready = 1'b1;
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    chk("post_rst_rempty", {31'd0, rempty}, 32'd1);
    chk("post_rst_valid", {31'd0, rd_if.dout_valid}, 32'd0);
    chk("post_rst_rptr", {27'd0, rptr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the dual-clock FIFO: owns the read pointer, generates the empty flag, drives the read address into the FIFO memory buffer, and presents popped words on a registered valid/ready output stage. Sits entirely in the read clock domain. It consumes the write pointer, already Gray-coded and double-synchronized into this domain by the external synchronizer. It returns its own Gray read pointer for synchronization into the write domain.

## Interface
- DATASIZE, 8, data word width; must match the FIFO memory.
- ADDRSIZE, 4, memory address bits; depth = 2^ADDRSIZE.

- rclk  in  1  read-domain clock; all state on rising edge
- rrst_n  in  1  reset, asynchronous assert, active-low
- rq2_wptr  in  ADDRSIZE+1  Gray write pointer, already synchronized to rclk
- rdata_mem  in  DATASIZE  combinational read data from memory at raddr
- dout_ready  in  1  consumer accepts dout this cycle
- raddr  out  ADDRSIZE  memory read address
- rptr  out  ADDRSIZE+1  registered Gray read pointer, to write-domain synchronizer
- rempty  out  1  registered empty flag
- dout  out  DATASIZE  output data register
- dout_valid  out  1  dout holds an unconsumed word
- rlevel  out  ADDRSIZE+1  registered occupancy estimate (see Configuration)

## Operation
- State: rbin (ADDRSIZE+1-bit binary read pointer), rptr (Gray of rbin), rempty, dout, dout_valid, rlevel.
- Reset values: rbin=0, rptr=0, raddr=0, rempty=1, dout=0, dout_valid=0, rlevel=0.
- raddr = rbin[ADDRSIZE-1:0].
- Internal fetch: rinc = !rempty && (!dout_valid || dout_ready).
- rbinnext = rbin + rinc, modulo 2^(ADDRSIZE+1); rgraynext = (rbinnext>>1) ^ rbinnext.
- On each edge: rbin<=rbinnext, rptr<=rgraynext, rempty<=(rgraynext == rq2_wptr).
- Output stage:
  - rinc=1: dout<=rdata_mem, dout_valid<=1.
  - rinc=0 and dout_valid && dout_ready: dout_valid<=0, dout holds its value.
  - Otherwise: hold.
- Simultaneous pop and fetch (dout_valid && dout_ready && !rempty): new word loads and dout_valid stays 1. This gives one word per cycle throughout.
- While dout_valid=1 and dout_ready=0, dout, rbin, and rptr are frozen.
- Wrap-around: the extra pointer MSB distinguishes laps. raddr wraps 2^ADDRSIZE-1→0, and rbin wraps 2^(ADDRSIZE+1)-1→0 without glitching rempty.
- No underflow is possible: memory is never read while rempty=1.
- Reset mid-operation: all state returns to reset values immediately. An in-flight dout word is discarded.

## Timing
- rempty is registered and lags an rq2_wptr change by 1 rclk. Total write-to-visible latency is therefore the 2-flop sync plus 1 cycle.
- Word available (rempty=0) at edge N → dout_valid=1 with that word after edge N+1.
- rptr advances on the same edge that loads dout. rptr changes at most one Gray bit per cycle.
- Throughput: 1 word/cycle while non-empty and dout_ready=1.
- rlevel is registered and valid 1 cycle after rbin or rq2_wptr settles.

## Configuration
- FIFO_RD_LEVEL_EN defined:
  - rlevel <= gray2bin(rq2_wptr) − rbinnext, computed modulo 2^(ADDRSIZE+1).
  - Range is 0..2^ADDRSIZE.
  - The value is conservative: it never overstates occupancy.
- Not defined: the subtractor and converter are not instantiated, and rlevel is tied to 0. All other behaviour is identical.

## Structure
- Shared package fifo_pkg holds:
  - default DATASIZE/ADDRSIZE localparams;
  - the pointer width rule PTRW = ADDRSIZE+1.
- Sub-module fifo_gray2bin: parameter WIDTH, combinational Gray-to-binary prefix XOR. Instantiated only under FIFO_RD_LEVEL_EN.

## Test plan
- Reset: hold rrst_n=0 with arbitrary inputs → rempty=1, dout_valid=0, rptr=0, raddr=0, rlevel=0. Assert rrst_n asynchronously mid-cycle → outputs clear before the next edge.
- Streaming: memory[0..2]=A0,A1,A2, rq2_wptr=gray(3)=5'b00010, dout_ready=1 → dout A0,A1,A2 on 3 consecutive cycles. Then rempty=1, dout_valid drops, rptr=5'b00010.
- Backpressure: 2 words present, dout_ready=0 → exactly one fetch; dout=word0 is held and rptr=gray(1). Raising dout_ready for 1 cycle → dout=word1 on the next edge.
- Wrap: ADDRSIZE=4, 40 words written sequentially with rq2_wptr stepped → raddr passes 15→0, rbin passes 31→0, data order preserved, no spurious rempty.
- Level (FIFO_RD_LEVEL_EN): rbin=4, rq2_wptr=gray(10) → rlevel=6 one cycle later. Repeat with rbin=30, wptr=2 → rlevel=4. Macro undefined → rlevel stays 0.
- Reset during stall: dout_valid=1, dout_ready=0, pull rrst_n low → dout_valid=0, rptr=0. After release with rq2_wptr=0 → rempty stays 1.
